// File: rtl/md_sched.sv
// Multiply/divide scheduler: tracks the MD unit's busy window and drives the pipeline stall controls.
// Accept is combinational; the busy window is MULT_CYC or DIV_CYC cycles; the hazard outputs are combinational.
module md_sched #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_start_E,
  input  logic [1:0]  md_op_E,
  input  logic        md_use_D,
  input  logic        stall_haz,
  output logic        md_go,
  output logic [1:0]  md_op_q,
  output logic        md_busy,
  output logic        hilo_we,
  output logic        En_PC,
  output logic        En_RegFD,
  output logic        Clr_RegDE,
  output logic [31:0] stall_cnt
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] MULT_LD = 4'(MULT_CYC);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYC);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        go, last, stall_md, stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      op_q        <= 2'b00;
      stall_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    go      = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (md_start_E) begin
          go      = 1'b1;
          op_d    = md_op_E;
          cnt_d   = md_op_E[1] ? DIV_LD : MULT_LD;
          state_d = RUN;
        end
      end
      RUN: begin
        // A start seen here can only come from a defective upstream; it is dropped.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          last    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Every pulse and stall output is forced quiet while reset is asserted.
  assign md_go     = go & ~reset;
  assign hilo_we   = last & ~reset;
  assign md_busy   = (state_q == RUN) & ~reset;
  assign stall_md  = md_use_D & (md_start_E | md_busy);
  assign stall     = (stall_md | stall_haz) & ~reset;

  assign En_PC     = ~stall;
  assign En_RegFD  = ~stall;
  assign Clr_RegDE = stall;
  assign md_op_q   = op_q;
  assign stall_cnt = stall_cnt_q;

  assign stall_cnt_d = (stall && (stall_cnt_q != 32'hFFFF_FFFF)) ? stall_cnt_q + 32'd1
                                                                  : stall_cnt_q;

endmodule
